cp0_exception_sequencer: RTL and testbench

//  Sequences exception entry and ERET return around coprocessor0 and the pipeline.
//  - Stalls fetch on CP0 pendingexception, drains in-flight instructions, then issues the one-cycle activeexception pulse to CP0.
//  - Flushes the pipe and hands the vector PC to fetch; on ERET, flushes and redirects to EPC.
//  - Sits between coprocessor0, the hazard/stall unit and the PC-select mux.

---
 rtl/cp0_exception_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cp0_exception_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_sequencer.sv
// Exception-entry / ERET-return sequencer between CP0, the hazard unit and the PC-select mux.
// Optional per-interrupt vectoring is enabled by defining CP0_VECTORED_INT_EN.
module cp0_exception_sequencer #(
  parameter logic [31:0] VECTOR_BASE  = 32'h8000_0000,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VEC_SPACING  = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] epc,
  input  logic        eret,
  input  logic        pipe_idle,
  input  logic        redirect_ready,
  output logic        stall_req,
  output logic        flush,
  output logic        activeexception,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    TAKE,
    EXC_REDIR,
    HANDLER,
    ERET_FLUSH,
    ERET_REDIR
  } state_t;

  localparam logic [3:0]  DRAIN_LOAD  = 4'(DRAIN_CYCLES);
  localparam logic [31:0] GENERAL_VEC = VECTOR_BASE + 32'h0000_0180;

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [3:0]  drain_cnt_next;
  logic [31:0] vector_pc;

  // Saturating decrement; the drain is complete once the decremented value reaches zero,
  // so the stall lasts DRAIN_CYCLES cycles before TAKE when the pipe is already idle.
  assign drain_cnt_next = (drain_cnt == 4'd0) ? 4'd0 : drain_cnt - 4'd1;

`ifdef CP0_VECTORED_INT_EN
  logic [2:0] ip_index;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    ip_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cause_ip[i]) ip_index = 3'(i);
    end
  end

  assign vector_pc = (exccode == 5'd0)
                   ? VECTOR_BASE + 32'h0000_0200 + (32'(ip_index) * VEC_SPACING)
                   : GENERAL_VEC;
`else
  logic unused_cause;
  assign unused_cause = ^{exccode, cause_ip};
  assign vector_pc    = GENERAL_VEC;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // update in this block sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      drain_cnt       <= 4'd0;
      stall_req       <= 1'b0;
      flush           <= 1'b0;
      activeexception <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
      in_handler      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An exception arriving with an ERET wins; the ERET is dropped.
          if (pendingexception) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
            stall_req <= 1'b1;
          end else if (eret) begin
            state     <= ERET_FLUSH;
            flush     <= 1'b1;
            stall_req <= 1'b1;
          end
        end

        DRAIN: begin
          drain_cnt <= drain_cnt_next;
          if (!pendingexception) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
            stall_req <= 1'b0;
          end else if ((drain_cnt_next == 4'd0) && pipe_idle) begin
            state           <= TAKE;
            activeexception <= 1'b1;
            flush           <= 1'b1;
          end
        end

        TAKE: begin
          state           <= EXC_REDIR;
          activeexception <= 1'b0;
          flush           <= 1'b0;
          redirect_valid  <= 1'b1;
          redirect_pc     <= vector_pc;
        end

        EXC_REDIR: begin
          if (redirect_ready) begin
            state          <= HANDLER;
            redirect_valid <= 1'b0;
            stall_req      <= 1'b0;
            in_handler     <= 1'b1;
          end
        end

        HANDLER: begin
          // No nesting: pendingexception is deliberately ignored here.
          if (eret) begin
            state     <= ERET_FLUSH;
            flush     <= 1'b1;
            stall_req <= 1'b1;
          end
        end

        ERET_FLUSH: begin
          state          <= ERET_REDIR;
          flush          <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= epc;
        end

        ERET_REDIR: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            stall_req      <= 1'b0;
            in_handler     <= 1'b0;
          end
        end

        default: begin
          state           <= IDLE;
          drain_cnt       <= 4'd0;
          stall_req       <= 1'b0;
          flush           <= 1'b0;
          activeexception <= 1'b0;
          redirect_valid  <= 1'b0;
          in_handler      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Directed self-checking bench for cp0_exception_sequencer (default parameters).
module tb_cp0_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pendingexception;
  logic [4:0]  exccode;
  logic [7:0]  cause_ip;
  logic [31:0] epc;
  logic        eret;
  logic        pipe_idle;
  logic        redirect_ready;
  logic        stall_req;
  logic        flush;
  logic        activeexception;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_handler;

  int tests = 0;
  int fails = 0;

`ifdef CP0_VECTORED_INT_EN
  localparam logic [31:0] IRQ_VEC = 32'h8000_02E0;
`else
  localparam logic [31:0] IRQ_VEC = 32'h8000_0180;
`endif
  localparam logic [31:0] GEN_VEC = 32'h8000_0180;

  cp0_exception_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pendingexception (pendingexception),
    .exccode          (exccode),
    .cause_ip         (cause_ip),
    .epc              (epc),
    .eret             (eret),
    .pipe_idle        (pipe_idle),
    .redirect_ready   (redirect_ready),
    .stall_req        (stall_req),
    .flush            (flush),
    .activeexception  (activeexception),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .in_handler       (in_handler)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Outputs packed as {stall_req, flush, activeexception, redirect_valid, in_handler}.
  task automatic check_ctl(input string tag, input logic [4:0] expected);
    check(tag, {27'd0, stall_req, flush, activeexception, redirect_valid, in_handler},
          {27'd0, expected});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    pendingexception = 1'b0;
    exccode          = 5'd0;
    cause_ip         = 8'h00;
    epc              = 32'd0;
    eret             = 1'b0;
    pipe_idle        = 1'b1;
    redirect_ready   = 1'b1;

    // Reset state
    #12;
    check_ctl("reset_ctl", 5'b00000);
    check("reset_pc", redirect_pc, 32'd0);
    reset = 1'b1;
    step();
    check_ctl("idle_after_reset", 5'b00000);

    // IRQ entry: cycle 0 below
    pendingexception = 1'b1;
    exccode          = 5'd0;
    cause_ip         = 8'b1000_1000;
    step();                                  // cycle 1
    check_ctl("irq_c1_stall", 5'b10000);
    step();                                  // cycle 2
    check_ctl("irq_c2_stall", 5'b10000);
    step();                                  // cycle 3
    check_ctl("irq_c3_stall", 5'b10000);
    step();                                  // cycle 4
    check_ctl("irq_c4_take", 5'b11100);
    step();                                  // cycle 5
    check_ctl("irq_c5_redir", 5'b10010);
    check("irq_c5_pc", redirect_pc, IRQ_VEC);
    step();                                  // cycle 6
    check_ctl("irq_c6_handler", 5'b00001);

    // Pending exception in HANDLER is ignored
    for (int i = 0; i < 3; i++) begin
      step();
      check_ctl("handler_ignore_pending", 5'b00001);
    end

    // ERET with 3 cycles of backpressure
    pendingexception = 1'b0;
    epc              = 32'h0040_0024;
    redirect_ready   = 1'b0;
    eret             = 1'b1;
    step();
    eret = 1'b0;
    check_ctl("eret_flush", 5'b11001);
    for (int i = 0; i < 3; i++) begin
      step();
      check_ctl("eret_redir_hold", 5'b10011);
      check("eret_redir_pc", redirect_pc, 32'h0040_0024);
    end
    redirect_ready = 1'b1;
    step();
    check_ctl("eret_done_idle", 5'b00000);

    // Drain wait: pipe_idle low for 6 cycles, non-interrupt exccode
    pendingexception = 1'b1;
    exccode          = 5'd4;
    pipe_idle        = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_ctl("drain_wait_stall", 5'b10000);
    end
    pipe_idle = 1'b1;
    step();
    check_ctl("drain_wait_take", 5'b11100);
    step();
    check_ctl("drain_wait_redir", 5'b10010);
    check("drain_wait_pc", redirect_pc, GEN_VEC);
    step();
    check_ctl("drain_wait_handler", 5'b00001);
    pendingexception = 1'b0;
    epc              = 32'hBFC0_0100;
    eret             = 1'b1;
    step();
    eret = 1'b0;
    step();
    check("eret2_pc", redirect_pc, 32'hBFC0_0100);
    step();
    check_ctl("eret2_idle", 5'b00000);

    // Abort: pendingexception drops during DRAIN
    pendingexception = 1'b1;
    step();
    check_ctl("abort_drain", 5'b10000);
    pendingexception = 1'b0;
    step();
    check_ctl("abort_idle", 5'b00000);
    step();
    step();
    check_ctl("abort_no_take", 5'b00000);

    // Simultaneous eret and pendingexception in IDLE: exception wins
    pendingexception = 1'b1;
    exccode          = 5'd0;
    eret             = 1'b1;
    redirect_ready   = 1'b0;
    step();
    eret = 1'b0;
    check_ctl("simul_exc_wins", 5'b10000);
    step();
    step();
    step();
    check_ctl("simul_take", 5'b11100);
    step();
    check_ctl("simul_redir", 5'b10010);

    // Reset during EXC_REDIR: outputs clear asynchronously
    reset = 1'b0;
    #1;
    check_ctl("async_reset_ctl", 5'b00000);
    check("async_reset_pc", redirect_pc, 32'd0);
    pendingexception = 1'b0;
    redirect_ready   = 1'b1;
    #2;
    reset = 1'b1;
    step();
    check_ctl("post_reset_idle", 5'b00000);

    // ERET from IDLE does not mark in_handler
    epc  = 32'h0000_1000;
    eret = 1'b1;
    step();
    eret = 1'b0;
    check_ctl("idle_eret_flush", 5'b11000);
    step();
    check_ctl("idle_eret_redir", 5'b10010);
    check("idle_eret_pc", redirect_pc, 32'h0000_1000);
    step();
    check_ctl("idle_eret_done", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
